// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
//  Module      : iter_divider
//  Description : Multi-cycle radix-2 restoring divider for DIV/DIVU. Takes one
//                signed DW-bit dividend/divisor pair (already sign- or
//                zero-extended by the requester), produces one quotient bit
//                per cycle, and returns quotient and remainder in a
//                byte-padded 2*FW-bit word with a one-cycle valid pulse.
//  Ports       :
//    clk                     rising-edge clock
//    reset                   asynchronous active-high reset
//    s_axis_dividend_tvalid  dividend valid
//    s_axis_dividend_tdata   dividend [DW-1:0]
//    s_axis_divisor_tvalid   divisor valid
//    s_axis_divisor_tdata    divisor [DW-1:0]
//    s_axis_tready           high while idle; request taken only when high
//    m_axis_dout_tvalid      one-cycle result-valid pulse
//    m_axis_dout_tdata       [FW+DW-1:FW] quotient, [DW-1:0] remainder,
//                            padding bits sign-extended
//  Revision    : 1.0 - initial release
// ============================================================================
module iter_divider #(
  parameter int DW = 33,
  parameter int FW = 40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_axis_dividend_tvalid,
  input  logic [DW-1:0]   s_axis_dividend_tdata,
  input  logic            s_axis_divisor_tvalid,
  input  logic [DW-1:0]   s_axis_divisor_tdata,
  output logic            s_axis_tready,
  output logic            m_axis_dout_tvalid,
  output logic [2*FW-1:0] m_axis_dout_tdata
);

  localparam int c_CNT_W = $clog2(DW);
  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(DW - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_CALC = 2'd1;
  localparam logic [1:0] c_S_FIX  = 2'd2;
  localparam logic [1:0] c_S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DW-1:0]      r_rem;       // partial remainder magnitude
  logic [DW-1:0]      r_quo;       // dividend bits shift out as quotient bits shift in
  logic [DW-1:0]      r_dvs;       // divisor magnitude
  logic [DW-1:0]      r_dvd;       // original dividend, returned on divide-by-zero
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_div_zero;
  logic [2*FW-1:0]    r_dout;

  logic               w_accept;
  logic [DW-1:0]      w_abs_dvd;
  logic [DW-1:0]      w_abs_dvs;
  logic [DW:0]        w_shift;
  logic [DW:0]        w_diff;
  logic [DW-1:0]      w_rem_next;
  logic [DW-1:0]      w_quo_next;
  logic [DW-1:0]      w_q_final;
  logic [DW-1:0]      w_r_final;
  logic [2*FW-1:0]    w_dout;

  assign w_accept  = (r_state == c_S_IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
  assign w_abs_dvd = s_axis_dividend_tdata[DW-1] ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
  assign w_abs_dvs = s_axis_divisor_tdata[DW-1]  ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;

  // One restoring step: the next dividend bit is the MSB of r_quo. The extra
  // top bit of the difference is the borrow, i.e. the trial went negative.
  assign w_shift = {r_rem, r_quo[DW-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_comb begin
    w_rem_next = w_shift[DW-1:0];
    w_quo_next = {r_quo[DW-2:0], 1'b0};
    if (!w_diff[DW]) begin
      w_rem_next = w_diff[DW-1:0];
      w_quo_next = {r_quo[DW-2:0], 1'b1};
    end
  end

  // Sign correction; divide-by-zero overrides the signs entirely.
  always_comb begin
    w_q_final = r_sign_q ? -r_quo : r_quo;
    w_r_final = r_sign_r ? -r_rem : r_rem;
    if (r_div_zero) begin
      w_q_final = '1;
      w_r_final = r_dvd;
    end
  end

  assign w_dout = {{(FW-DW){w_q_final[DW-1]}}, w_q_final,
                   {(FW-DW){w_r_final[DW-1]}}, w_r_final};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_dvd      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_div_zero <= 1'b0;
      r_dout     <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_accept) begin
            r_rem      <= '0;
            r_quo      <= w_abs_dvd;
            r_dvs      <= w_abs_dvs;
            r_dvd      <= s_axis_dividend_tdata;
            r_sign_q   <= s_axis_dividend_tdata[DW-1] ^ s_axis_divisor_tdata[DW-1];
            r_sign_r   <= s_axis_dividend_tdata[DW-1];
            r_div_zero <= (s_axis_divisor_tdata == '0);
            r_cnt      <= '0;
            r_state    <= c_S_CALC;
          end
        end
        c_S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt == c_LAST_STEP) begin
            r_cnt   <= '0;
            r_state <= c_S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_S_FIX: begin
          r_dout  <= w_dout;
          r_state <= c_S_DONE;
        end
        c_S_DONE: begin
          r_state <= c_S_IDLE;
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready      = (r_state == c_S_IDLE);
  assign m_axis_dout_tvalid = (r_state == c_S_DONE);
  assign m_axis_dout_tdata  = r_dout;

endmodule
`default_nettype wire
